// File: rtl/data_mem_responder.sv
// Word-addressed data RAM responder for the load/store unit: byte-masked stores,
// full-word loads, fixed wait states, out-of-range error and response back-pressure.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 30,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_mask,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;

  logic              accept, enter_resp;
  logic              acc_write, acc_in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_mask;
  logic [31:0]       acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       rd_word;

  logic [31:0] mem [DEPTH_WORDS];

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // request side is ready only in IDLE, and a response is held until taken.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so it must
  // use the live request rather than the latched copy.
  assign acc_write    = (state_q == S_IDLE) ? req_write : wr_q;
  assign acc_addr     = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign acc_mask     = (state_q == S_IDLE) ? req_mask  : mask_q;
  assign acc_wdata    = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign acc_in_range = ({1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH_WORDS));
  assign acc_idx      = acc_addr[IDX_W-1:0];
  assign rd_word      = mem[acc_idx];
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      mask_q     <= 4'd0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        mask_q  <= req_mask;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        resp_error <= !acc_in_range;
        resp_rdata <= (!acc_write && acc_in_range) ? rd_word : 32'd0;
      end else if (resp_valid && resp_ready) begin
        resp_rdata <= 32'd0;
        resp_error <= 1'b0;
      end
    end
  end

  // RAM is not reset; gating on rst_n keeps a store from committing during reset.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && acc_write && acc_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
